// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares the single RAM port between the instruction fetch requester and the
// data requester. One transaction is granted at a time. Data requests have
// priority, but a starvation guard forces an instruction grant after
// STARVE_MAX consecutive data grants while a fetch is pending. A watchdog
// aborts a grant that sees ERROR, or that waits too long for ACCESS. After an
// abort the requester's wait stays high, so the requester retries by itself.
//
// Ports
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN, iaddr          instruction read request / word address
//   iload, iwait         instruction read data / request still pending
//   dREN, dWEN           data read / write request (never both)
//   daddr, dstore        data address / write value
//   dload, dwait         data read data / request still pending
//   ramREN, ramWEN       RAM strobes
//   ramaddr, ramstore    RAM address / write data
//   ramload, ramstate    RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   memerr               one-cycle pulse after an aborted transaction
module memory_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT, RECOVER} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    // Abort in the grant cycle that would bring the no-ACCESS count to TIMEOUT.
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  starve_cnt;
    logic [7:0]  to_cnt;
    logic        data_req;
    logic        access;
    logic        granted;

    assign data_req = dREN | dWEN;
    assign access   = (ramstate == RAM_ACCESS);
    assign granted  = (state == DGRANT) || (state == IGRANT);

    // Read data is a straight pass-through; valid only while the wait is low.
    assign iload = ramload;
    assign dload = ramload;
    assign iwait = iREN & ~((state == IGRANT) & access);
    assign dwait = data_req & ~((state == DGRANT) & access);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        memerr     = 1'b0;
        case (state)
            IDLE: begin
                if (data_req && (starve_cnt < STARVE_LIM)) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end else if (data_req) begin
                    next_state = DGRANT;
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramREN   = dREN;
                ramWEN   = dWEN;
                // ACCESS wins over a simultaneous withdrawal; a withdrawal
                // wins over an abort, since nobody is left to retry.
                if (access || !data_req) begin
                    next_state = IDLE;
                end else if ((ramstate == RAM_ERROR) || (to_cnt == TO_LAST)) begin
                    next_state = RECOVER;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (access || !iREN) begin
                    next_state = IDLE;
                end else if ((ramstate == RAM_ERROR) || (to_cnt == TO_LAST)) begin
                    next_state = RECOVER;
                end
            end
            RECOVER: begin
                memerr     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Every grant is entered from IDLE, so clearing outside grants covers
    // "clear on entry". The count saturates instead of wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            to_cnt <= '0;
        end else if (!granted) begin
            to_cnt <= '0;
        end else if (!access && (to_cnt != 8'hFF)) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    // Consecutive data completions while a fetch waits; saturating.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (!iREN) begin
            starve_cnt <= '0;
        end else if ((state == IGRANT) && access) begin
            starve_cnt <= '0;
        end else if ((state == DGRANT) && access && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter that shares the single RAM port between the instruction fetch requester (icache/fetch stage) and the data requester (dcache/MEM stage) of the pipelined CPU. It sits between the caches and the RAM model, granting one transaction at a time. Data requests have priority, and an instruction starvation guard bounds how long fetch can wait. A watchdog aborts stuck RAM transactions. The iwait/dwait outputs it produces are the stall inputs consumed by the hazard unit (via ihit/dhit).

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while iREN is pending before instruction is forced next; range 1..15.
- TIMEOUT, 255: cycles a granted transaction may go without ACCESS before abort; range 1..255, 8-bit counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset; asynchronous and active-low.
- iREN  in  1  instruction read request; held until iwait falls.
- iaddr  in  32  instruction word address.
- iload  out  32  instruction read data; equals ramload.
- iwait  out  1  instruction request not yet completed.
- dREN  in  1  data read request; held until dwait falls.
- dWEN  in  1  data write request; held until dwait falls; never asserted together with dREN.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data; equals ramload.
- dwait  out  1  data request not yet completed.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memerr  out  1  one-cycle pulse when a transaction is aborted on ERROR or timeout.

## Operation
- FSM states: IDLE, DGRANT, IGRANT, RECOVER.
- IDLE: all ram outputs are 0.
  - If dREN|dWEN and starve count < STARVE_MAX, go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else if a data request is pending, go to DGRANT.
  - Else stay in IDLE.
- DGRANT:
  - Drive ramaddr=daddr and ramstore=dstore.
  - Drive ramREN=dREN and ramWEN=dWEN.
- IGRANT:
  - Drive ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion: a granted state sees ramstate==ACCESS.
  - That same cycle, the granted wait output is 0.
  - Next state is IDLE.
- Abort: a granted state sees ramstate==ERROR, or the timeout counter reaches TIMEOUT.
  - Go to RECOVER; memerr pulses high during the RECOVER cycle.
  - Wait stays 1, so the requester retries automatically.
- RECOVER: ram outputs are 0; go to IDLE next cycle.
- Withdrawal: the granted requester drops its enable before ACCESS.
  - Go to IDLE next cycle; no memerr.
- Wait outputs:
  - iwait = iREN & ~(IGRANT & ramstate==ACCESS).
  - dwait = (dREN|dWEN) & ~(DGRANT & ramstate==ACCESS).
- Starve counter (4-bit):
  - Increments on each DGRANT completion while iREN=1.
  - Clears on IGRANT completion, or in any cycle with iREN=0.
  - Saturates at STARVE_MAX.
- Timeout counter:
  - Clears on entry to a grant state.
  - Increments each grant cycle without ACCESS.
  - Does not wrap.

## Timing
- Reset (async, nRST=0):
  - state=IDLE, starve=0, timeout=0, memerr=0.
  - ram outputs are 0.
  - iwait and dwait follow the request inputs combinationally.
- Reset asserted mid-transaction drops ramREN/ramWEN immediately, without waiting for a clock edge; no memerr.
- Arbitration latency: a request seen in IDLE at edge N gives grant strobes after edge N.
- Minimum transaction: 2 cycles (IDLE, then grant with ACCESS in the first cycle).
- Back-to-back transactions always pass through one IDLE cycle.
- Simultaneous iREN and data request in IDLE with starve < STARVE_MAX: data wins.
- Simultaneous ACCESS and request withdrawal: treated as completion.
- ERROR and timeout in the same cycle: a single memerr pulse.
- iload and dload are valid only in the cycle their wait is 0.

## Test plan
- Lone fetch: iREN=1, iaddr=0x40, ramstate BUSY×2 then ACCESS with ramload=0x8C010004.
  - Required: iwait low exactly in the ACCESS cycle, with iload=0x8C010004.
  - Required: ramREN high for 3 cycles.
- Contention: iREN and dWEN raised together, daddr=0x100, dstore=0xDEAD.
  - Required: DGRANT first, with ramWEN=1 and ramstore=0xDEAD.
  - Required: IGRANT starts 2 cycles after data completion.
- Starvation: iREN held high while dREN is reasserted continuously.
  - Required: after exactly 4 data grants, IGRANT occurs before the 5th data grant.
- Timeout: grant with ramstate stuck BUSY for 255 cycles.
  - Required: memerr pulses 1 cycle, wait stays 1, the transaction is reissued from IDLE.
- Error: ramstate=ERROR in the 1st DGRANT cycle.
  - Required: RECOVER, memerr=1 for one cycle; retry completes on the next ACCESS.
- Async reset mid-DGRANT: nRST low between edges.
  - Required: ramWEN falls immediately, state IDLE, starve=0, no memerr.
